// File: rtl/program_counter_unit.sv
// Fetch-stage PC register with valid/ready handshake, stall, redirect bubble and boot cycle.
// Optional misaligned-target trap enabled by defining PC_ALIGN_CHECK_EN.
module program_counter_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] NextPC,
  input  logic        Redirect,
  input  logic        Stall,
  input  logic        OutReady,
  output logic [31:0] PCResult,
  output logic [31:0] PCPlus4,
  output logic        OutValid
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic        Misaligned
`endif
);

`ifdef PC_ALIGN_CHECK_EN
  typedef enum logic [1:0] {StBoot, StRun, StBubble, StHalt} state_e;
`else
  typedef enum logic [1:0] {StBoot, StRun, StBubble} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        load;

`ifdef PC_ALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;
  logic bad_target;
  assign bad_target = (NextPC[1:0] != 2'b00);
`else
  logic unused_next_pc_low;
  assign unused_next_pc_low = ^NextPC[1:0];
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    OutValid = 1'b0;
    load     = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    misaligned_d = misaligned_q;
`endif
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        OutValid = 1'b1;
        // Redirect outranks stall, and ignores OutReady.
        if (Redirect) begin
          load    = 1'b1;
          state_d = StBubble;
        end else if (!Stall && OutReady) begin
          load = 1'b1;
        end
      end
      StBubble: begin
        if (Redirect) begin
          load = 1'b1;
        end else begin
          state_d = StRun;
        end
      end
`ifdef PC_ALIGN_CHECK_EN
      StHalt: ;
`endif
      default: state_d = StBoot;
    endcase

    if (load) begin
`ifdef PC_ALIGN_CHECK_EN
      // Offending target is dropped; only reset leaves the trap.
      if (bad_target) begin
        state_d      = StHalt;
        misaligned_d = 1'b1;
      end else begin
        pc_d = NextPC;
      end
`else
      pc_d = {NextPC[31:2], 2'b00};
`endif
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end
  assign Misaligned = misaligned_q;
`endif

  assign PCResult = pc_q;
  assign PCPlus4  = pc_q + PC_STEP;

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed scoreboard bench for program_counter_unit; the next-PC mux is modelled
// in the bench so NextPC follows PCPlus4 unless Redirect selects the target.
module tb_program_counter_unit;

  logic        clk;
  logic        reset;
  logic [31:0] next_pc;
  logic        redirect;
  logic        stall;
  logic        out_ready;
  logic [31:0] pc_result;
  logic [31:0] pc_plus4;
  logic        out_valid;
  logic [31:0] target;
`ifdef PC_ALIGN_CHECK_EN
  logic        misaligned;
`endif

  int tests  = 0;
  int failed = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        valid;
  } exp_t;

  exp_t sb[$];

  program_counter_unit dut (
    .Clk        (clk),
    .Reset      (reset),
    .NextPC     (next_pc),
    .Redirect   (redirect),
    .Stall      (stall),
    .OutReady   (out_ready),
    .PCResult   (pc_result),
    .PCPlus4    (pc_plus4),
    .OutValid   (out_valid)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .Misaligned (misaligned)
`endif
  );

  assign next_pc = redirect ? target : pc_plus4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare();
    exp_t e;
    tests++;
    assert (sb.size() != 0) else begin
      failed++;
      $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      tests++;
      assert (pc_result === e.pc) else begin
        failed++;
        $error("FAIL %s pc: observed %h expected %h", e.tag, pc_result, e.pc);
      end
      tests++;
      assert (pc_plus4 === e.pc + 32'd4) else begin
        failed++;
        $error("FAIL %s plus4: observed %h expected %h", e.tag, pc_plus4, e.pc + 32'd4);
      end
      tests++;
      assert (out_valid === e.valid) else begin
        failed++;
        $error("FAIL %s valid: observed %b expected %b", e.tag, out_valid, e.valid);
      end
    end
  endtask

  // Expect the given state after the next rising edge.
  task automatic step(input string tag, input logic [31:0] epc, input logic ev);
    sb.push_back('{tag, epc, ev});
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic check_now(input string tag, input logic [31:0] epc, input logic ev);
    sb.push_back('{tag, epc, ev});
    compare();
  endtask

`ifdef PC_ALIGN_CHECK_EN
  task automatic check_mis(input string tag, input logic ev);
    tests++;
    assert (misaligned === ev) else begin
      failed++;
      $error("FAIL %s misaligned: observed %b expected %b", tag, misaligned, ev);
    end
  endtask
`endif

  initial begin
    reset     = 1'b0;
    redirect  = 1'b0;
    stall     = 1'b0;
    out_ready = 1'b1;
    target    = 32'h0;

    // Reset held for three cycles.
    #1;
    check_now("in_reset", 32'h0, 1'b0);
    step("in_reset_1", 32'h0, 1'b0);
    step("in_reset_2", 32'h0, 1'b0);
    step("in_reset_3", 32'h0, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
    check_mis("in_reset", 1'b0);
`endif
    reset = 1'b1;
    check_now("boot", 32'h0, 1'b0);
    step("first_valid", 32'h0, 1'b1);
    step("seq_4", 32'h4, 1'b1);
    step("seq_8", 32'h8, 1'b1);

    // Stall, then backpressure.
    stall = 1'b1;
    step("stall_1", 32'h8, 1'b1);
    step("stall_2", 32'h8, 1'b1);
    stall     = 1'b0;
    out_ready = 1'b0;
    step("bp_1", 32'h8, 1'b1);
    step("bp_2", 32'h8, 1'b1);
    out_ready = 1'b1;
    step("resume_c", 32'hC, 1'b1);

    // Redirect beats stall and costs one bubble.
    redirect = 1'b1;
    stall    = 1'b1;
    target   = 32'h100;
    step("redir_bubble", 32'h100, 1'b0);
    redirect = 1'b0;
    stall    = 1'b0;
    step("redir_valid", 32'h100, 1'b1);
    step("redir_next", 32'h104, 1'b1);

    // Wrap-around.
    redirect = 1'b1;
    target   = 32'hFFFF_FFFC;
    step("wrap_bubble", 32'hFFFF_FFFC, 1'b0);
    redirect = 1'b0;
    step("wrap_valid", 32'hFFFF_FFFC, 1'b1);
    step("wrap_zero", 32'h0, 1'b1);

    // Back-to-back redirects stretch the bubble.
    redirect = 1'b1;
    target   = 32'h200;
    step("b2b_1", 32'h200, 1'b0);
    target = 32'h300;
    step("b2b_2", 32'h300, 1'b0);
    redirect = 1'b0;
    step("b2b_valid", 32'h300, 1'b1);
    out_ready = 1'b0;

    // Misaligned target.
    redirect = 1'b1;
    target   = 32'h102;
`ifdef PC_ALIGN_CHECK_EN
    step("mis_halt", 32'h300, 1'b0);
    check_mis("mis_set", 1'b1);
    redirect  = 1'b0;
    out_ready = 1'b1;
    step("mis_frozen_1", 32'h300, 1'b0);
    step("mis_frozen_2", 32'h300, 1'b0);
    check_mis("mis_sticky", 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_now("mis_reset", 32'h0, 1'b0);
    check_mis("mis_cleared", 1'b0);
    reset = 1'b1;
    step("mis_reboot", 32'h0, 1'b1);
`else
    step("mis_masked", 32'h100, 1'b0);
    redirect  = 1'b0;
    out_ready = 1'b1;
    step("mis_masked_valid", 32'h100, 1'b1);
`endif

    // Async reset between edges at PC 0x40.
    redirect = 1'b1;
    target   = 32'h40;
    step("to_40_bubble", 32'h40, 1'b0);
    redirect  = 1'b0;
    out_ready = 1'b0;
    step("at_40", 32'h40, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    check_now("async_reset", 32'h0, 1'b0);
    #2;
    reset     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_now("post_reset_boot", 32'h0, 1'b1);
    step("post_reset_seq", 32'h4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
